// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// and a DMA/debug port.
// - Arbitration is per cycle. When both sides request in the same cycle, the
//   one that was not granted last wins (round-robin).
// - A DMA request starts a locked burst of dma_req_len+1 words. The address
//   auto-increments from the sampled base.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_req_* / cpu_rsp_*   CPU valid/ready request, one-cycle read response
//   dma_req_* / dma_rsp_*   DMA beat valid/ready, one-cycle read response
//   dma_done            pulses the cycle after the final burst beat
//   mem_*               data_mem drive (combinational) and its combinational
//                       read data
module dmem_arbiter #(
  parameter int BURST_LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_we,
  input  logic [31:0]            cpu_req_addr,
  input  logic [31:0]            cpu_req_wdata,
  output logic                   cpu_rsp_valid,
  output logic [31:0]            cpu_rsp_rdata,
  input  logic                   dma_req_valid,
  output logic                   dma_req_ready,
  input  logic                   dma_req_we,
  input  logic [31:0]            dma_req_addr,
  input  logic [BURST_LEN_W-1:0] dma_req_len,
  input  logic [31:0]            dma_req_wdata,
  output logic                   dma_rsp_valid,
  output logic [31:0]            dma_rsp_rdata,
  output logic                   dma_done,
  output logic                   mem_read_en,
  output logic                   mem_write_en,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  typedef enum logic {IDLE, DMA_BURST} state_t;

  state_t                 state_q, state_d;
  logic                   last_dma_q;     // 1: DMA held the most recent grant
  logic [31:0]            burst_addr_q;   // address of the next burst beat
  logic                   burst_we_q;
  logic [BURST_LEN_W-1:0] remain_q;       // beats left after the first one
  logic                   cpu_rsp_valid_q, dma_rsp_valid_q, dma_done_q;
  logic [31:0]            cpu_rsp_rdata_q, dma_rsp_rdata_q;

  logic        grant_cpu, grant_dma, acc_we;
  logic [31:0] acc_addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_dma && dma_req_len != '0) state_d = DMA_BURST;
      DMA_BURST: if (grant_dma && remain_q == BURST_LEN_W'(1)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: grants, readies and the memory drive
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    acc_addr  = '0;
    acc_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      if (state_q == DMA_BURST) begin
        // Burst is locked: the beat address and direction come from the
        // burst registers. The live DMA addr, we and len inputs are ignored.
        grant_dma = dma_req_valid;
      end else begin
        grant_cpu = cpu_req_valid && (!dma_req_valid || last_dma_q);
        grant_dma = dma_req_valid && !grant_cpu;
      end
    end
    if (grant_cpu) begin
      acc_addr  = cpu_req_addr;
      acc_we    = cpu_req_we;
      mem_wdata = cpu_req_wdata;
    end else if (grant_dma) begin
      acc_addr  = (state_q == DMA_BURST) ? burst_addr_q : dma_req_addr;
      acc_we    = (state_q == DMA_BURST) ? burst_we_q   : dma_req_we;
      mem_wdata = dma_req_wdata;
    end
    cpu_req_ready = grant_cpu;
    dma_req_ready = grant_dma;
    mem_read_en   = (grant_cpu || grant_dma) && !acc_we;
    mem_write_en  = (grant_cpu || grant_dma) &&  acc_we;
    mem_addr      = acc_addr & 32'hFFFF_FFFC;
  end

  // Burst bookkeeping and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma_q      <= 1'b1;
      burst_addr_q    <= '0;
      burst_we_q      <= 1'b0;
      remain_q        <= '0;
      cpu_rsp_valid_q <= 1'b0;
      dma_rsp_valid_q <= 1'b0;
      dma_done_q      <= 1'b0;
      cpu_rsp_rdata_q <= '0;
      dma_rsp_rdata_q <= '0;
    end else begin
      cpu_rsp_valid_q <= grant_cpu && !acc_we;
      dma_rsp_valid_q <= grant_dma && !acc_we;
      dma_done_q      <= 1'b0;
      if (grant_cpu) begin
        last_dma_q <= 1'b0;
        if (!acc_we) cpu_rsp_rdata_q <= mem_rdata;
      end
      if (grant_dma) begin
        last_dma_q <= 1'b1;
        if (!acc_we) dma_rsp_rdata_q <= mem_rdata;
        // The next beat follows the word just accessed. This holds for the
        // first beat too, because mem_addr is the aligned base.
        burst_addr_q <= mem_addr + 32'd4;
        if (state_q == IDLE) begin
          burst_we_q <= dma_req_we;
          remain_q   <= dma_req_len;
          dma_done_q <= (dma_req_len == '0);
        end else begin
          remain_q   <= remain_q - BURST_LEN_W'(1);
          dma_done_q <= (remain_q == BURST_LEN_W'(1));
        end
      end
    end
  end

  assign cpu_rsp_valid = cpu_rsp_valid_q;
  assign cpu_rsp_rdata = cpu_rsp_rdata_q;
  assign dma_rsp_valid = dma_rsp_valid_q;
  assign dma_rsp_rdata = dma_rsp_rdata_q;
  assign dma_done      = dma_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic        clk, rst, tb_init;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_rsp_rdata;
  logic        cpu_rsp_valid;
  logic        dma_req_valid, dma_req_ready, dma_req_we;
  logic [31:0] dma_req_addr, dma_req_wdata, dma_rsp_rdata;
  logic [3:0]  dma_req_len;
  logic        dma_rsp_valid, dma_done;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.BURST_LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
    .dma_req_len(dma_req_len), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
    .dma_done(dma_done),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem stand-in: 256 words, combinational read, write at the edge
  logic [31:0] tmem [0:255];
  always @(posedge clk) begin
    if (tb_init) for (int k = 0; k < 256; k++) tmem[k] <= '0;
    else if (mem_write_en) tmem[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = tmem[mem_addr[9:2]];

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else passes++;
  endtask

  // Reference model: the burst as "words left", the arbitration as "who wins the next tie".
  logic [31:0] ref_mem [0:255];
  int          m_left;
  logic [31:0] m_addr;
  logic        m_we, m_cpu_wins;
  logic        m_gc, m_gd, m_inb, m_w;
  logic [31:0] m_a, m_wd;
  logic        e_cvld, e_dvld, e_done;
  logic [31:0] e_crd, e_drd;

  task automatic drive(input logic r, input logic cv, input logic cwe, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic dv, input logic dwe,
                       input logic [31:0] da, input logic [3:0] dl, input logic [31:0] dwd);
    rst = r; cpu_req_valid = cv; cpu_req_we = cwe; cpu_req_addr = ca; cpu_req_wdata = cwd;
    dma_req_valid = dv; dma_req_we = dwe; dma_req_addr = da; dma_req_len = dl;
    dma_req_wdata = dwd;
  endtask

  // Called at posedge+1 with inputs applied; checks combinational outputs mid-cycle.
  task automatic check_comb();
    m_gc = 0; m_gd = 0; m_inb = (m_left != 0); m_a = 0; m_w = 0; m_wd = 0;
    if (!rst) begin
      if (m_inb) begin
        m_gd = dma_req_valid; m_a = m_addr; m_w = m_we; m_wd = dma_req_wdata;
      end else begin
        m_gc = cpu_req_valid && (!dma_req_valid || m_cpu_wins);
        m_gd = dma_req_valid && !m_gc;
        m_a  = m_gc ? cpu_req_addr  : dma_req_addr;
        m_w  = m_gc ? cpu_req_we    : dma_req_we;
        m_wd = m_gc ? cpu_req_wdata : dma_req_wdata;
      end
    end
    if (!(m_gc || m_gd)) begin m_a = 0; m_w = 0; m_wd = 0; end
    m_a[1:0] = 2'b00;
    #4;
    chk("comb", {cpu_req_ready, dma_req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata},
        {m_gc, m_gd, (m_gc || m_gd) && !m_w, (m_gc || m_gd) && m_w, m_a, m_wd});
  endtask

  // Updates the model, crosses the clock edge and checks the registered outputs.
  task automatic advance();
    logic [31:0] rd;
    rd = ref_mem[m_a[9:2]];
    e_done = 0;
    if (rst) begin
      m_left = 0; m_cpu_wins = 1; e_cvld = 0; e_dvld = 0; e_crd = 0; e_drd = 0;
    end else begin
      e_cvld = m_gc && !m_w; if (e_cvld) e_crd = rd;
      e_dvld = m_gd && !m_w; if (e_dvld) e_drd = rd;
      if (m_gd && m_inb) begin
        m_addr = m_addr + 4; m_left--; e_done = (m_left == 0);
      end else if (m_gd) begin
        m_left = int'(dma_req_len); m_addr = m_a + 4; m_we = dma_req_we; m_cpu_wins = 1;
        e_done = (dma_req_len == 0);
      end else if (m_gc) m_cpu_wins = 0;
      if ((m_gc || m_gd) && m_w) ref_mem[m_a[9:2]] = m_wd;
    end
    @(posedge clk); #1;
    chk("post", {cpu_rsp_valid, cpu_rsp_rdata, dma_rsp_valid, dma_rsp_rdata, dma_done},
        {e_cvld, e_crd, e_dvld, e_drd, e_done});
  endtask

  task automatic step();
    check_comb();
    advance();
  endtask

  typedef struct {
    logic r, cv, cwe; logic [31:0] ca, cwd;
    logic dv, dwe; logic [31:0] da; logic [3:0] dl; logic [31:0] dwd;
    logic [69:0] ec;  // {cpu_ready, dma_ready, ren, wen, addr, wdata}
    logic [66:0] ep;  // {cpu_rsp_valid, cpu_rdata, dma_rsp_valid, dma_rdata, done}
  } vec_t;

  function automatic logic [69:0] C(input logic cr, input logic dr, input logic re,
                                    input logic we, input logic [31:0] a, input logic [31:0] w);
    return {cr, dr, re, we, a, w};
  endfunction
  function automatic logic [66:0] P(input logic cv, input logic [31:0] cd, input logic dv,
                                    input logic [31:0] dd, input logic dn);
    return {cv, cd, dv, dd, dn};
  endfunction

  vec_t vt [13];
  int   npulse;
  logic cv_hold, dv_hold;

  initial begin
    // Reset, CPU write/read, alternating grants, then a 4-beat DMA write burst.
    vt[0]  = '{1,1,0,32'h404,0,        1,0,32'h408,0,0, C(0,0,0,0,0,0),          P(0,0,0,0,0)};
    vt[1]  = '{0,1,1,32'h404,32'hDEADBEEF, 0,0,0,0,0,   C(1,0,0,1,32'h404,32'hDEADBEEF), P(0,0,0,0,0)};
    vt[2]  = '{0,1,0,32'h406,0,        0,0,0,0,0,       C(1,0,1,0,32'h404,0),    P(1,32'hDEADBEEF,0,0,0)};
    vt[3]  = '{1,0,0,0,0,              0,0,0,0,0,       C(0,0,0,0,0,0),          P(0,0,0,0,0)};
    vt[4]  = '{0,1,0,32'h404,0,        1,0,32'h40A,0,0, C(1,0,1,0,32'h404,0),    P(1,32'hDEADBEEF,0,0,0)};
    vt[5]  = '{0,1,0,32'h404,0,        1,0,32'h40A,0,0, C(0,1,1,0,32'h408,0),    P(0,32'hDEADBEEF,1,0,1)};
    vt[6]  = '{0,1,0,32'h404,0,        1,0,32'h40A,0,0, C(1,0,1,0,32'h404,0),    P(1,32'hDEADBEEF,0,0,0)};
    vt[7]  = '{0,1,0,32'h404,0,        1,0,32'h40A,0,0, C(0,1,1,0,32'h408,0),    P(0,32'hDEADBEEF,1,0,1)};
    vt[8]  = '{0,0,0,0,0,              1,1,32'h400,3,1, C(0,1,0,1,32'h400,1),    P(0,32'hDEADBEEF,0,0,0)};
    vt[9]  = '{0,1,0,32'h404,0,        1,0,32'h123,0,2, C(0,1,0,1,32'h404,2),    P(0,32'hDEADBEEF,0,0,0)};
    vt[10] = '{0,1,0,32'h404,0,        1,0,32'h123,0,3, C(0,1,0,1,32'h408,3),    P(0,32'hDEADBEEF,0,0,0)};
    vt[11] = '{0,1,0,32'h404,0,        1,0,32'h123,0,4, C(0,1,0,1,32'h40C,4),    P(0,32'hDEADBEEF,0,0,1)};
    vt[12] = '{0,1,0,32'h404,0,        0,0,0,0,0,       C(1,0,1,0,32'h404,0),    P(1,32'h2,0,0,0)};

    for (int k = 0; k < 256; k++) ref_mem[k] = '0;
    m_left = 0; m_addr = 0; m_we = 0; m_cpu_wins = 1;
    tb_init = 1;
    drive(1,0,0,0,0,0,0,0,0,0);
    @(posedge clk); #1;
    tb_init = 0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].r, vt[i].cv, vt[i].cwe, vt[i].ca, vt[i].cwd,
            vt[i].dv, vt[i].dwe, vt[i].da, vt[i].dl, vt[i].dwd);
      check_comb();
      chk($sformatf("tbl%0d_comb", i),
          {cpu_req_ready, dma_req_ready, mem_read_en, mem_write_en, mem_addr, mem_wdata}, vt[i].ec);
      advance();
      chk($sformatf("tbl%0d_post", i),
          {cpu_rsp_valid, cpu_rsp_rdata, dma_rsp_valid, dma_rsp_rdata, dma_done}, vt[i].ep);
    end

    // Read burst len=2 at 0x400 (holds 1,2,3) with a two-cycle stall after beat 1.
    npulse = 0;
    drive(0,0,0,0,0, 1,0,32'h400,2,0);
    check_comb(); chk("stall_b0_addr", mem_addr, 32'h400);
    advance(); npulse += int'(dma_rsp_valid); chk("stall_b0_data", dma_rsp_rdata, 32'h1);
    for (int s = 0; s < 2; s++) begin
      drive(0,1,0,32'h404,0, 0,0,0,0,0);
      check_comb(); chk("stall_noacc", {mem_read_en, mem_write_en, cpu_req_ready}, 3'b000);
      advance(); npulse += int'(dma_rsp_valid);
    end
    drive(0,1,0,32'h404,0, 1,1,32'h0,0,0);
    check_comb(); chk("stall_b1_addr", mem_addr, 32'h404);
    advance(); npulse += int'(dma_rsp_valid); chk("stall_b1_data", dma_rsp_rdata, 32'h2);
    check_comb(); chk("stall_b2_addr", mem_addr, 32'h408);
    advance(); npulse += int'(dma_rsp_valid); chk("stall_b2_data", dma_rsp_rdata, 32'h3);
    chk("stall_done", dma_done, 1'b1);
    chk("stall_pulses", npulse, 3);
    drive(0,1,0,32'h404,0, 0,0,0,0,0); step();

    // Address wrap at the top of the address space.
    drive(0,0,0,0,0, 1,0,32'hFFFF_FFF8,2,0);
    check_comb(); chk("wrap_a0", mem_addr, 32'hFFFF_FFF8); advance();
    check_comb(); chk("wrap_a1", mem_addr, 32'hFFFF_FFFC); advance();
    check_comb(); chk("wrap_a2", mem_addr, 32'h0000_0000); advance();
    chk("wrap_done", dma_done, 1'b1);

    // Reset after beat 2 of an 8-beat write burst.
    drive(0,0,0,0,0, 1,1,32'h440,7,32'hA5A5_0001); step();
    drive(0,0,0,0,0, 1,1,32'h440,7,32'hA5A5_0002); step();
    drive(1,0,0,0,0, 1,1,32'h440,7,32'hA5A5_0003);
    check_comb(); chk("rst_outs", {cpu_req_ready, dma_req_ready, mem_read_en, mem_write_en}, 4'b0);
    advance(); chk("rst_nodone", {dma_done, cpu_rsp_valid, dma_rsp_valid}, 3'b000);
    drive(0,1,0,32'h440,0, 1,0,32'h800,0,0);
    check_comb(); chk("rst_cpu_grant", {cpu_req_ready, mem_addr}, {1'b1, 32'h440});
    advance(); chk("rst_kept_beat", cpu_rsp_rdata, 32'hA5A5_0001);
    drive(0,0,0,0,0, 1,0,32'h800,0,0); step();

    // Random traffic against the model; a losing requester holds its request.
    cv_hold = 0; dv_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(299) == 0);
      if (!cv_hold) begin
        cpu_req_valid = $urandom_range(1); cpu_req_we = $urandom_range(1);
        cpu_req_addr  = ($urandom_range(7) == 0) ? (32'hFFFF_FF00 | $urandom_range(255))
                                                 : $urandom_range(1023);
        cpu_req_wdata = $urandom;
      end
      if (!dv_hold) begin
        dma_req_valid = $urandom_range(1); dma_req_we = $urandom_range(1);
        dma_req_addr  = ($urandom_range(7) == 0) ? (32'hFFFF_FF00 | $urandom_range(255))
                                                 : $urandom_range(1023);
        dma_req_len   = 4'($urandom_range(15));
        dma_req_wdata = $urandom;
      end
      check_comb();
      cv_hold = !rst && cpu_req_valid && !m_gc;
      dv_hold = !rst && dma_req_valid && !m_gd && !m_inb;
      advance();
      chk("rsp_excl", cpu_rsp_valid && dma_rsp_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
